// File: rtl/fifo_pkg.sv
// Shared helpers for the stream FIFO family: widths, pointer wrap, parameter legality.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package fifo_pkg;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer into a depth-entry array; never narrower than 1 bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Advance a pointer and wrap at depth-1 by compare, so non-power-of-two
  // depths never visit unused slots.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

  // Legal configuration: depth >= 2 and 0 <= aempty < afull <= depth.
  function automatic bit params_ok(input int depth, input int afull, input int aempty);
    return (depth >= 2) && (aempty >= 0) && (aempty < afull) && (afull <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for stream_fifo: one synchronous write port, one asynchronous read port.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller decides when we is allowed.
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out (combinational).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are intentionally not reset; occupancy tracking makes stale words invisible.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Synchronous elastic buffer with valid/ready on both sides and first-word-fall-through output.
// Latency: word written at edge N is on data_out with r_valid from edge N; flags/count lag by one edge.
// Backpressure: w_ready = !fifo_full (registered, no ready-through); r_valid = !fifo_empty.
// Ports: clk, reset (sync, active-high), flush; w_valid/w_ready/data_in write side;
//        r_valid/r_ready/data_out read side; count, fifo_full/empty, almost_full/empty,
//        sticky overflow/underflow.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 4,
  parameter  int AFULL_TH  = DEPTH - 1,
  parameter  int AEMPTY_TH = 1,
  localparam int CW        = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = ptr_width(DEPTH);

  if (!params_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("stream_fifo: illegal DEPTH/AFULL_TH/AEMPTY_TH combination");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          wr_fire;
  logic          rd_fire;

  assign w_ready = !fifo_full;
  assign r_valid = !fifo_empty;

  // Handshakes in a reset or flush cycle are dropped entirely, including the storage write.
  assign wr_fire = w_valid && w_ready && !flush && !reset;
  assign rd_fire = r_valid && r_ready && !flush && !reset;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

  always_comb begin
    count_nxt = count;
    case ({wr_fire, rd_fire})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are registered from count_nxt so they change on the same edge as count.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
      if (rd_fire) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
      count        <= count_nxt;
      fifo_full    <= (count_nxt == CW'(DEPTH));
      fifo_empty   <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AFULL_TH));
      almost_empty <= (count_nxt <= CW'(AEMPTY_TH));
      overflow     <= overflow  || (w_valid && !w_ready);
      underflow    <= underflow || (r_ready && !r_valid);
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush_a, flush_b;

  // DUT A: DEPTH=3, default thresholds (AFULL_TH=2, AEMPTY_TH=1)
  logic        a_wv, a_wr, a_rv, a_rr, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [31:0] a_din, a_dout;
  logic [1:0]  a_cnt;

  // DUT B: DEPTH=5, AFULL_TH=4, AEMPTY_TH=1
  logic        b_wv, b_wr, b_rv, b_rr, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [31:0] b_din, b_dout;
  logic [2:0]  b_cnt;

  stream_fifo #(.WIDTH(32), .DEPTH(3)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a),
    .w_valid(a_wv), .w_ready(a_wr), .data_in(a_din),
    .r_valid(a_rv), .r_ready(a_rr), .data_out(a_dout),
    .fifo_full(a_full), .fifo_empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
  );

  stream_fifo #(.WIDTH(32), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b),
    .w_valid(b_wv), .w_ready(b_wr), .data_in(b_din),
    .r_valid(b_rv), .r_ready(b_rr), .data_out(b_dout),
    .fifo_full(b_full), .fifo_empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ea, eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs change just after posedge, so the negedge sees the handshake
  // that the next posedge will take.
  always @(negedge clk) begin
    if (a_rv && a_rr) begin
      vectors++;
      if (qa.size() == 0) begin
        miscompares++;
        $display("FAIL a_data: read of %0h with no word expected", a_dout);
      end else begin
        ea = qa.pop_front();
        if (a_dout !== ea) begin
          miscompares++;
          $display("FAIL a_data: got %0h, required %0h", a_dout, ea);
        end
      end
    end
    if (b_rv && b_rr) begin
      vectors++;
      if (qb.size() == 0) begin
        miscompares++;
        $display("FAIL b_data: read of %0h with no word expected", b_dout);
      end else begin
        eb = qb.pop_front();
        if (b_dout !== eb) begin
          miscompares++;
          $display("FAIL b_data: got %0h, required %0h", b_dout, eb);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    a_wv = 0; a_rr = 0; a_din = '0;
    b_wv = 0; b_rr = 0; b_din = '0;
    step(); step();
    reset = 1'b0;

    // ---- reset state (DEPTH=3)
    chk("a_rst_count", 32'(a_cnt), 0);
    chk("a_rst_empty", 32'(a_empty), 1);
    chk("a_rst_full", 32'(a_full), 0);
    chk("a_rst_w_ready", 32'(a_wr), 1);
    chk("a_rst_r_valid", 32'(a_rv), 0);
    chk("a_rst_aempty", 32'(a_ae), 1);
    chk("a_rst_afull", 32'(a_af), 0);
    chk("a_rst_ovf", 32'(a_ovf), 0);
    chk("a_rst_unf", 32'(a_unf), 0);

    // ---- fill 0,1,2 back to back
    a_wv = 1;
    for (int i = 0; i < 3; i++) begin
      a_din = i;
      qa.push_back(i);
      step();
      chk("a_fill_count", 32'(a_cnt), i + 1);
      chk("a_fill_full", 32'(a_full), (i == 2) ? 1 : 0);
      chk("a_fill_afull", 32'(a_af), (i + 1 >= 2) ? 1 : 0);
    end
    // word 3 offered while full: rejected, overflow set
    a_din = 3;
    chk("a_full_w_ready", 32'(a_wr), 0);
    step();
    a_wv = 0;
    chk("a_ovf_set", 32'(a_ovf), 1);
    chk("a_ovf_count", 32'(a_cnt), 3);

    // ---- drain 3, then one read while empty
    a_rr = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("a_drain_count", 32'(a_cnt), 2 - i);
      chk("a_drain_empty", 32'(a_empty), (i == 2) ? 1 : 0);
    end
    chk("a_unf_before", 32'(a_unf), 0);
    step();
    a_rr = 0;
    chk("a_unf_set", 32'(a_unf), 1);
    chk("a_unf_count", 32'(a_cnt), 0);
    chk("a_ovf_sticky", 32'(a_ovf), 1);

    // ---- flush with a write at count 3 and overflow set
    a_wv = 1;
    for (int i = 0; i < 3; i++) begin
      a_din = 32'h50 + i;
      step();
    end
    a_din = 32'hDEAD_BEEF;
    flush_a = 1;
    step();
    flush_a = 0;
    a_wv = 0;
    chk("a_flush_count", 32'(a_cnt), 0);
    chk("a_flush_ovf", 32'(a_ovf), 0);
    chk("a_flush_unf", 32'(a_unf), 0);
    chk("a_flush_r_valid", 32'(a_rv), 0);
    a_wv = 1;
    a_din = 32'hA5A5_A5A5;
    qa.push_back(32'hA5A5_A5A5);
    step();
    a_wv = 0;
    chk("a_flush_next_count", 32'(a_cnt), 1);
    chk("a_flush_head", a_dout, 32'hA5A5_A5A5);
    a_rr = 1;
    step();
    a_rr = 0;

    // ---- reset mid-operation discards stored words
    a_wv = 1;
    a_din = 32'h77; step();
    a_din = 32'h88; step();
    a_wv = 0;
    reset = 1;
    step();
    reset = 0;
    chk("a_midrst_count", 32'(a_cnt), 0);
    chk("a_midrst_r_valid", 32'(a_rv), 0);
    a_wv = 1;
    a_din = 32'h11;
    qa.push_back(32'h11);
    step();
    a_wv = 0;
    a_rr = 1;
    step();
    a_rr = 0;
    chk("a_midrst_empty", 32'(a_empty), 1);

    // ---- DEPTH=5: threshold walk, fill to 5 and drain to 0
    b_wv = 1;
    for (int i = 0; i < 5; i++) begin
      b_din = 32'h100 + i;
      qb.push_back(32'h100 + i);
      step();
      chk("b_up_count", 32'(b_cnt), i + 1);
      chk("b_up_afull", 32'(b_af), (i + 1 >= 4) ? 1 : 0);
      chk("b_up_aempty", 32'(b_ae), (i + 1 <= 1) ? 1 : 0);
    end
    b_wv = 0;
    chk("b_full", 32'(b_full), 1);
    b_rr = 1;
    for (int c = 4; c >= 0; c--) begin
      step();
      chk("b_dn_count", 32'(b_cnt), c);
      chk("b_dn_afull", 32'(b_af), (c >= 4) ? 1 : 0);
      chk("b_dn_aempty", 32'(b_ae), (c <= 1) ? 1 : 0);
    end
    b_rr = 0;
    chk("b_dn_empty", 32'(b_empty), 1);

    // ---- DEPTH=5: 12 writes with reads, simultaneous at count 2, across wrap
    b_wv = 1;
    for (int i = 0; i < 2; i++) begin
      b_din = 32'h200 + i;
      qb.push_back(32'h200 + i);
      step();
    end
    chk("b_pre_sim_count", 32'(b_cnt), 2);
    b_rr = 1;
    for (int i = 2; i < 10; i++) begin
      b_din = 32'h200 + i;
      qb.push_back(32'h200 + i);
      step();
      chk("b_sim_count", 32'(b_cnt), 2);
    end
    b_rr = 0;
    for (int i = 10; i < 12; i++) begin
      b_din = 32'h200 + i;
      qb.push_back(32'h200 + i);
      step();
    end
    b_wv = 0;
    chk("b_post_count", 32'(b_cnt), 4);
    b_rr = 1;
    for (int c = 3; c >= 0; c--) begin
      step();
      chk("b_final_count", 32'(b_cnt), c);
    end
    b_rr = 0;
    chk("b_no_ovf", 32'(b_ovf), 0);
    chk("b_no_unf", 32'(b_unf), 0);

    step();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous FIFO with valid/ready handshakes on both sides, first-word-fall-through read data, occupancy count, programmable almost-full/almost-empty flags and sticky error flags. It is the next generation of the team's simple `w_valid`/`r_ready` FIFO. Depth may be any integer ≥ 2, not only a power of two. It sits between SoC stream producers and consumers, for example DMA-to-accelerator paths, as the standard elastic buffer.

## Interface
- `WIDTH`, 32, data word width in bits.
- `DEPTH`, 4, number of entries; ≥ 2; need not be a power of two.
- `AFULL_TH`, DEPTH-1, `almost_full` asserts when count ≥ AFULL_TH.
- `AEMPTY_TH`, 1, `almost_empty` asserts when count ≤ AEMPTY_TH. Legal range: 0 ≤ AEMPTY_TH < AFULL_TH ≤ DEPTH.
- `CW` (localparam), `$clog2(DEPTH+1)`, width of `count`.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous clear of contents and error flags.
- `w_valid` input 1: write request.
- `w_ready` output 1: FIFO can accept a write; equals `!fifo_full`.
- `data_in` input WIDTH: write data.
- `r_valid` output 1: `data_out` holds a valid word; equals `!fifo_empty`.
- `r_ready` input 1: consumer accepts `data_out`.
- `data_out` output WIDTH: head-of-FIFO word (fall-through).
- `fifo_full`, `fifo_empty`, `almost_full`, `almost_empty` output 1 each: status flags.
- `count` output CW: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky; set when a write is attempted while full (`w_valid && !w_ready`).
- `underflow` output 1: sticky; set when a read is attempted while empty (`r_ready && !r_valid`).

## Operation
- Write fires when `w_valid && w_ready`: `data_in` is stored at `wr_ptr`, and `wr_ptr` advances.
- Read fires when `r_valid && r_ready`: `rd_ptr` advances.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
- `count` update per edge: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Simultaneous read and write with 0 < count < DEPTH: both fire, count is unchanged.
- Full: `w_ready`=0, so no write fires even if a read fires in the same cycle. No combinational ready-through path.
- Empty: `r_valid`=0. No bypass of `data_in` to `data_out`; a written word is readable from the next cycle.
- `data_out` = `mem[rd_ptr]`, combinational from the storage read port. Its value is don't-care while `r_valid`=0.
- Flags are registered and derived from the next value of `count`, so they always agree with `count` in the same cycle:
  - `fifo_full` = (count==DEPTH)
  - `fifo_empty` = (count==0)
  - `almost_full` = (count ≥ AFULL_TH)
  - `almost_empty` = (count ≤ AEMPTY_TH)
- Priority: `reset` > `flush` > normal handshake.
- `flush` behaves like reset except it has its own port. Any handshake in a flush cycle is ignored: no write is stored and no read is counted.
- Reset values: pointers 0, `count`=0, `fifo_empty`=1, `r_valid`=0, `fifo_full`=0, `w_ready`=1, `almost_empty`=1 (since AEMPTY_TH ≥ 0), `almost_full`=0, `overflow`=0, `underflow`=0. Memory contents are not reset.
- Reset mid-operation discards all stored data. The first write after reset is the first word read.

## Timing
- Write-to-read latency: a word written at edge N is visible on `data_out` with `r_valid`=1 from edge N onward (usable in cycle N+1).
- Status flags and `count` change only on clock edges, one edge after the causing handshake.
- Sustained throughput is 1 write and 1 read per cycle when not full or empty.
- `overflow`/`underflow` set at the edge following the offending cycle. They hold until `reset` or `flush`.

## Structure
- Shared package `fifo_pkg` holds:
  - pointer-increment-with-wrap function `ptr_inc(ptr, depth)`;
  - count-width helper;
  - elaboration-time parameter legality checks.
- Sub-module `fifo_mem`: WIDTH×DEPTH register array, one synchronous write port, one asynchronous read port.
- Control logic (pointers, count, flags, sticky errors) lives in `stream_fifo`.

## Test plan
- Reset, no traffic (WIDTH=32, DEPTH=3) -> `fifo_empty`=1, `count`=0, `w_ready`=1, `r_valid`=0, `almost_empty`=1.
- Write 0,1,2 back-to-back, then write 3 -> `count` reads 1,2,3; `fifo_full` only after the third write; word 3 rejected; `overflow`=1.
- From full: read 3 words, then 1 more `r_ready` -> `data_out` sequence 0,1,2; `fifo_empty`=1 after the third read; `underflow`=1.
- DEPTH=5, 12 writes interleaved with reads, including simultaneous read+write at count 2 -> data order preserved across pointer wrap; `count` unchanged on the simultaneous cycle.
- AFULL_TH=4, AEMPTY_TH=1, DEPTH=5: fill to 5, drain to 0 -> `almost_full` asserts at count 4 and clears at 3; `almost_empty` asserts at 1.
- `flush` asserted together with `w_valid` at count 3, overflow set -> `count`=0, `overflow`=0, word not stored. Next write 0xA5A5A5A5 is the head on `data_out`.
